// File: rtl/key_led_array_if.sv
// Key/LED bundle: raw keys and mode in, debounced key events and LED drive out.
interface key_led_array_if #(
    parameter int N_KEYS = 4,
    parameter int LED_W  = 4
);
    logic [N_KEYS-1:0] key_in;
    logic              mode;
    logic [N_KEYS-1:0] key_flag;
    logic [N_KEYS-1:0] key_state;
    logic [N_KEYS-1:0] long_flag;
    logic [LED_W-1:0]  led;

    modport master (output key_in, mode, input key_flag, key_state, long_flag, led);
    modport slave  (input key_in, mode, output key_flag, key_state, long_flag, led);
endinterface

// File: rtl/key_led_array.sv
// Purpose: per-key sync + debounce + long-press detect, driving a counter/toggle LED register.
// Latency: key_flag 2+DEB_CYC cycles after a stable key change; led updates 1 cycle after key_flag.
// Backpressure: none; events are single-cycle pulses that are always consumed.
module key_led_array #(
    parameter int N_KEYS   = 4,
    parameter int LED_W    = 4,
    parameter int DEB_CYC  = 1000000,
    parameter int LONG_CYC = 50000000
) (
    input  logic          Clk,
    input  logic          Rst,
    key_led_array_if.slave bus
);
    localparam int DEB_W  = $clog2(DEB_CYC);
    localparam int LONG_W = $clog2(LONG_CYC);
    localparam int N_TOG  = (N_KEYS < LED_W) ? N_KEYS : LED_W;
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYC - 1);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYC - 1);

    typedef enum logic [1:0] {IDLE, FILT_DN, DOWN, FILT_UP} deb_state_t;

    logic [N_KEYS-1:0] flag_w, state_w, long_w, press_w;
    logic [LED_W-1:0]  led_q, led_d;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        logic              s1, s2;
        deb_state_t        state_q, state_d;
        logic [DEB_W-1:0]  filt_q, filt_d;
        logic [LONG_W-1:0] hold_q, hold_d;
        logic              done_q, done_d;
        logic              press_now, rel_now, long_now;

        always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
                s1      <= 1'b1;
                s2      <= 1'b1;
                state_q <= IDLE;
                filt_q  <= '0;
                hold_q  <= '0;
                done_q  <= 1'b0;
            end else begin
                s1      <= bus.key_in[k];
                s2      <= s1;
                state_q <= state_d;
                filt_q  <= filt_d;
                hold_q  <= hold_d;
                done_q  <= done_d;
            end
        end

        always_comb begin
            state_d   = state_q;
            filt_d    = filt_q;
            hold_d    = hold_q;
            done_d    = done_q;
            press_now = 1'b0;
            rel_now   = 1'b0;
            long_now  = 1'b0;
            // Hold time keeps running through release filtering; done_q limits to one pulse per press.
            if (state_q == DOWN || state_q == FILT_UP) begin
                if (hold_q != LONG_MAX) hold_d = hold_q + LONG_W'(1);
                if (hold_q == LONG_MAX && !done_q) begin
                    long_now = 1'b1;
                    done_d   = 1'b1;
                end
            end
            case (state_q)
                IDLE: if (!s2) begin
                    state_d = FILT_DN;
                    filt_d  = '0;
                end
                FILT_DN: begin
                    if (s2) begin
                        state_d = IDLE;
                    end else if (filt_q == DEB_MAX) begin
                        state_d   = DOWN;
                        press_now = 1'b1;
                        hold_d    = '0;
                        done_d    = 1'b0;
                    end else begin
                        filt_d = filt_q + DEB_W'(1);
                    end
                end
                DOWN: if (s2) begin
                    state_d = FILT_UP;
                    filt_d  = '0;
                end
                FILT_UP: begin
                    if (!s2) begin
                        state_d = DOWN;
                    end else if (filt_q == DEB_MAX) begin
                        state_d = IDLE;
                        rel_now = 1'b1;
                    end else begin
                        filt_d = filt_q + DEB_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // key_state flips in the same cycle as the flag, so it is derived from the terminal-count terms.
        assign flag_w[k]  = press_now | rel_now;
        assign state_w[k] = (state_q == DOWN || state_q == FILT_UP) ? rel_now : ~press_now;
        assign long_w[k]  = long_now;
        assign press_w[k] = press_now;
    end

    always_comb begin
        led_d = led_q;
        if (bus.mode) begin
            for (int i = 0; i < N_TOG; i++) begin
                if (press_w[i]) led_d[i] = ~led_q[i];
            end
        end else if (long_w[0]) begin
            led_d = '0;
        end else if (press_w[0] && !press_w[1]) begin
            led_d = led_q + LED_W'(1);
        end else if (press_w[1] && !press_w[0]) begin
            led_d = led_q - LED_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) led_q <= '0;
        else     led_q <= led_d;
    end

    assign bus.key_flag  = flag_w;
    assign bus.key_state = state_w;
    assign bus.long_flag = long_w;
    assign bus.led       = led_q;
endmodule

// File: tb/tb_key_led_array.sv
// Directed bench for key_led_array with DEB_CYC=4, LONG_CYC=20, four keys and four LEDs.
module tb_key_led_array;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    key_led_array_if #(.N_KEYS(4), .LED_W(4)) bus ();

    key_led_array #(
        .N_KEYS(4), .LED_W(4), .DEB_CYC(4), .LONG_CYC(20)
    ) dut (
        .Clk(clk),
        .Rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    int press_cnt [4];
    int rel_cnt   [4];
    int long_cnt  [4];

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (bus.key_flag[k] && !bus.key_state[k]) press_cnt[k]++;
            if (bus.key_flag[k] &&  bus.key_state[k]) rel_cnt[k]++;
            if (bus.long_flag[k]) long_cnt[k]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        bus.key_in = ~mask;
        cycles(hold);
        bus.key_in = 4'hF;
        cycles(12);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t_press, t_long, t_rel, ks6, led7, led26, led27;
        int p0, r0, l0, p1, r1, p3, r3, l_all;
        logic ks_low;

        bus.key_in = 4'hF;
        bus.mode   = 1'b0;
        rst        = 1'b1;
        cycles(3);
        check("reset_led", bus.led, 4'h0);
        check("reset_key_state", bus.key_state, 4'hF);
        check("reset_key_flag", bus.key_flag, 4'h0);
        check("reset_long_flag", bus.long_flag, 4'h0);
        rst = 1'b0;
        cycles(2);
        check("idle_key_state", bus.key_state, 4'hF);

        // Clean long press on key0, counter mode.
        p0 = press_cnt[0]; r0 = rel_cnt[0]; l0 = long_cnt[0];
        t_press = -1; t_long = -1; ks6 = -1; led7 = -1; led26 = -1; led27 = -1;
        bus.key_in[0] = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            cycles(1);
            if (bus.key_flag[0] && t_press < 0) t_press = c;
            if (bus.long_flag[0] && t_long < 0) t_long = c;
            if (c == 6)  ks6   = int'(bus.key_state[0]);
            if (c == 7)  led7  = int'(bus.led);
            if (c == 26) led26 = int'(bus.led);
            if (c == 27) led27 = int'(bus.led);
        end
        check("clean_press_cycle", t_press, 6);
        check("clean_press_state", ks6, 0);
        check("clean_led_after_press", led7, 1);
        check("clean_long_cycle", t_long, 26);
        check("clean_led_before_clear", led26, 1);
        check("clean_led_after_long", led27, 0);
        bus.key_in[0] = 1'b1;
        t_rel = -1;
        for (int c = 1; c <= 12; c++) begin
            cycles(1);
            if (bus.key_flag[0] && t_rel < 0) t_rel = c;
        end
        check("clean_release_cycle", t_rel, 6);
        check("clean_press_count", press_cnt[0] - p0, 1);
        check("clean_long_count", long_cnt[0] - l0, 1);
        check("clean_release_count", rel_cnt[0] - r0, 1);
        check("clean_key_state_end", bus.key_state, 4'hF);
        check("clean_led_end", bus.led, 4'h0);

        // Bounce on key1 every 2 cycles.
        p1 = press_cnt[1]; r1 = rel_cnt[1];
        ks_low = 1'b0;
        for (int j = 0; j < 10; j++) begin
            bus.key_in[1] = j[0];
            for (int c = 0; c < 2; c++) begin
                cycles(1);
                if (!bus.key_state[1]) ks_low = 1'b1;
            end
        end
        bus.key_in[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cycles(1);
            if (!bus.key_state[1]) ks_low = 1'b1;
        end
        check("bounce_flags", (press_cnt[1] - p1) + (rel_cnt[1] - r1), 0);
        check("bounce_state_low", ks_low, 1'b0);
        check("bounce_led", bus.led, 4'h0);

        // Counter wrap both ways.
        l_all = long_cnt[0] + long_cnt[1];
        press(4'b0010, 8);
        check("wrap_dec", bus.led, 4'hF);
        press(4'b0001, 8);
        check("wrap_inc", bus.led, 4'h0);
        check("short_no_long", long_cnt[0] + long_cnt[1] - l_all, 0);

        // Simultaneous presses.
        p0 = press_cnt[0]; p1 = press_cnt[1];
        press(4'b0011, 8);
        check("sim_cnt_led", bus.led, 4'h0);
        check("sim_cnt_press0", press_cnt[0] - p0, 1);
        check("sim_cnt_press1", press_cnt[1] - p1, 1);
        bus.mode = 1'b1;
        press(4'b0101, 8);
        check("sim_toggle_led", bus.led, 4'b0101);

        // Mode switch keeps led.
        press(4'b0110, 8);
        check("mode_setup_led", bus.led, 4'b0011);
        bus.mode = 1'b0;
        cycles(1);
        check("mode_switch_hold", bus.led, 4'b0011);
        press(4'b0001, 8);
        check("mode_switch_inc", bus.led, 4'b0100);

        // Reset while key3 is filtering a press.
        bus.mode = 1'b1;
        press(4'b1110, 8);
        check("rst_setup_led", bus.led, 4'hA);
        p3 = press_cnt[3]; r3 = rel_cnt[3];
        bus.key_in[3] = 1'b0;
        cycles(4);
        check("rst_prefilter_flag", bus.key_flag, 4'h0);
        rst = 1'b1;
        cycles(1);
        check("rst_mid_led", bus.led, 4'h0);
        check("rst_mid_flag", bus.key_flag, 4'h0);
        check("rst_mid_state", bus.key_state, 4'hF);
        cycles(2);
        rst = 1'b0;
        t_press = -1; led7 = -1;
        for (int c = 1; c <= 10; c++) begin
            cycles(1);
            if (bus.key_flag[3] && t_press < 0) t_press = c;
            if (c == 7) led7 = int'(bus.led);
        end
        check("rst_fresh_press_cycle", t_press, 6);
        check("rst_toggle_led3", led7, 4'b1000);
        check("rst_press_count", press_cnt[3] - p3, 1);
        bus.key_in[3] = 1'b1;
        cycles(12);
        check("rst_release_count", rel_cnt[3] - r3, 1);
        check("rst_led_final", bus.led, 4'b1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
